// File: rtl/iter_shifter_ms_pkg.sv
// rtl/iter_shifter_ms_pkg.sv - mode codes, FSM states and helpers for the iterative shifter
package iter_shifter_ms_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Codes above ROR are pass-through and never iterate.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return m <= MODE_ROR;
  endfunction

endpackage

// File: rtl/iter_shifter_ms_if.sv
// rtl/iter_shifter_ms_if.sv - request/result handshake bundle for the iterative shifter
interface iter_shifter_ms_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   amount;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             busy;

  modport master (
    output in_valid, data_in, amount, mode, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, amount, mode, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/iter_shifter_ms_shift_step_unit.sv
// rtl/iter_shifter_ms_shift_step_unit.sv - one-step combinational shifter/rotator
module shift_step_unit
  import iter_shifter_ms_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   dist_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [SHW:0] W_FULL = (SHW+1)'(WIDTH);

  // One extra bit so a zero distance yields a full-width complementary shift (which clears).
  logic [SHW:0] inv_dist;
  assign inv_dist = W_FULL - {1'b0, dist_i};

  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_SLL: data_o = data_i << dist_i;
      MODE_SRL: data_o = data_i >> dist_i;
      MODE_SRA: data_o = $unsigned($signed(data_i) >>> dist_i);
      MODE_ROL: data_o = (data_i << dist_i) | (data_i >> inv_dist);
      MODE_ROR: data_o = (data_i >> dist_i) | (data_i << inv_dist);
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter_ms.sv
// rtl/iter_shifter_ms.sv - multi-cycle shift/rotate engine, up to STEP bits per cycle
module iter_shifter_ms
  import iter_shifter_ms_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              abort,
  iter_shifter_ms_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [2:0]       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] step_out;
  logic             in_ready, accept;

  // k never exceeds count_q (< WIDTH), so it always fits in SHW bits.
  assign k = (int'(count_q) > STEP) ? SHW'(STEP) : count_q;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .data_i (work_q),
    .dist_i (k),
    .mode_i (mode_q),
    .data_o (step_out)
  );

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready & ~abort;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    mode_d      = mode_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (count_q != '0) begin
            work_d  = step_out;
            count_d = count_q - k;
          end else begin
            data_out_d  = work_q;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: ;
      endcase
      // A new request overrides the DONE->IDLE return so results stream without a bubble.
      if (accept) begin
        work_d  = bus.data_in;
        count_d = is_shift_mode(bus.mode) ? bus.amount : '0;
        mode_d  = bus.mode;
        state_d = ST_SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.busy      = (state_q == ST_SHIFT) | (state_q == ST_DONE);

endmodule

// File: tb/tb_iter_shifter_ms.sv
// tb/tb_iter_shifter_ms.sv - scoreboard bench for iter_shifter_ms at STEP 4, 1 and 32
module tb_iter_shifter_ms;
  import iter_shifter_ms_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  iter_shifter_ms_if #(.WIDTH(32)) bus4 ();
  iter_shifter_ms_if #(.WIDTH(32)) bus1 ();
  iter_shifter_ms_if #(.WIDTH(32)) bus32 ();

  iter_shifter_ms #(.WIDTH(32), .STEP(4))  dut4  (.clk(clk), .rst(rst), .abort(abort), .bus(bus4.slave));
  iter_shifter_ms #(.WIDTH(32), .STEP(1))  dut1  (.clk(clk), .rst(rst), .abort(abort), .bus(bus1.slave));
  iter_shifter_ms #(.WIDTH(32), .STEP(32)) dut32 (.clk(clk), .rst(rst), .abort(abort), .bus(bus32.slave));

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic [2:0]  m;
    logic [31:0] e;
  } vec_t;

  exp_t sb4[$];
  exp_t sb1[$];
  exp_t sb32[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_result;

  function automatic logic [31:0] model(input logic [31:0] d, input int amt, input logic [2:0] m);
    logic [31:0] r;
    r = d;
    if (m > 3'd4) return d;
    for (int i = 0; i < amt; i++) begin
      case (m)
        3'd0:    r = {r[30:0], 1'b0};
        3'd1:    r = {1'b0, r[31:1]};
        3'd2:    r = {r[31], r[31:1]};
        3'd3:    r = {r[30:0], r[31]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input int amt, input logic [2:0] m, input int step);
    if (m > 3'd4) return 1;
    return (amt + step - 1) / step + 1;
  endfunction

  function automatic vec_t spec_vec(input int i);
    vec_t v;
    case (i)
      0:       v = '{32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000};
      1:       v = '{32'h8000_00F0, 5'd5,  3'b010, 32'hFC00_0007};
      2:       v = '{32'h8000_00F0, 5'd5,  3'b001, 32'h0400_0007};
      3:       v = '{32'h1234_5678, 5'd8,  3'b100, 32'h7812_3456};
      4:       v = '{32'h1234_5678, 5'd0,  3'b011, 32'h1234_5678};
      default: v = '{32'hDEAD_BEEF, 5'd17, 3'b110, 32'hDEAD_BEEF};
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    bus4.in_valid = 1'b0;  bus4.out_ready = 1'b0;  bus4.data_in = '0;  bus4.amount = '0;  bus4.mode = '0;
    bus1.in_valid = 1'b0;  bus1.out_ready = 1'b0;  bus1.data_in = '0;  bus1.amount = '0;  bus1.mode = '0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.data_in = '0; bus32.amount = '0; bus32.mode = '0;
  endtask

  // Called just after a negedge with the unit ready; returns at the negedge after the accept edge.
  task automatic send4(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m, input logic [31:0] e);
    exp_t x;
    x.data = e;
    x.lat  = exp_lat(int'(a), m, 4);
    sb4.push_back(x);
    bus4.data_in  = d;
    bus4.amount   = a;
    bus4.mode     = m;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.data_in  = $urandom;
    bus4.amount   = 5'($urandom);
    bus4.mode     = 3'($urandom);
  endtask

  task automatic wait_out4(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lat++;
      if (bus4.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume4();
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus4.out_valid); end
    n_cmp++; if (bus4.data_out !== 32'h0) begin n_err++; $display("FAIL reset_data_out got %h want 0", bus4.data_out); end
    n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus4.busy); end
    n_cmp++; if ({bus4.in_ready, bus1.in_ready, bus32.in_ready} !== 3'b111) begin
      n_err++; $display("FAIL reset_in_ready got %b want 111", {bus4.in_ready, bus1.in_ready, bus32.in_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t v;
    exp_t e;
    int lat;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        v = spec_vec(i);
      end else begin
        v.d = $urandom;
        v.a = 5'($urandom_range(0, 31));
        v.m = 3'($urandom_range(0, 4));
        v.e = model(v.d, int'(v.a), v.m);
      end
      send4(v.d, v.a, v.m, v.e);
      if (i == 0) begin
        n_cmp++; if (bus4.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", bus4.busy); end
      end
      wait_out4(lat, ok);
      e = sb4.pop_front();
      n_cmp++; if (!ok || bus4.data_out !== e.data) begin
        n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, bus4.data_out, e.data);
      end
      n_cmp++; if (lat != e.lat) begin
        n_err++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, e.lat);
      end
      last_result = e.data;
      consume4();
    end
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop got %b want 0", bus4.out_valid); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    bit ok;
    bit stable;
    send4(32'hA5A5_0001, 5'd4, MODE_SLL, 32'h5A50_0010);
    wait_out4(lat, ok);
    e = sb4.pop_front();
    n_cmp++; if (!ok || bus4.data_out !== e.data) begin n_err++; $display("FAIL hold_first got %h want %h", bus4.data_out, e.data); end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus4.out_valid !== 1'b1 || bus4.data_out !== e.data) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL hold_stable got %b/%h want 1/%h", bus4.out_valid, bus4.data_out, e.data); end
    bus4.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus4.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", bus4.in_ready); end
    send4(32'h0000_00FF, 5'd4, MODE_ROR, 32'hF000_000F);
    bus4.out_ready = 1'b0;
    n_cmp++; if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept got valid=%b busy=%b want 0/1", bus4.out_valid, bus4.busy);
    end
    wait_out4(lat, ok);
    e = sb4.pop_front();
    n_cmp++; if (!ok || bus4.data_out !== e.data) begin n_err++; $display("FAIL b2b_data got %h want %h", bus4.data_out, e.data); end
    n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, e.lat); end
    last_result = e.data;
    consume4();
  endtask

  task automatic test_abort();
    bit rose;
    send4(32'h0000_0003, 5'd20, MODE_SLL, 32'h0030_0000);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(sb4.pop_back());
    n_cmp++; if (bus4.busy !== 1'b0 || bus4.in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_idle got busy=%b in_ready=%b want 0/1", bus4.busy, bus4.in_ready);
    end
    n_cmp++; if (bus4.data_out !== last_result) begin n_err++; $display("FAIL abort_data_kept got %h want %h", bus4.data_out, last_result); end
    rose = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus4.out_valid) rose = 1'b1;
    end
    n_cmp++; if (rose) begin n_err++; $display("FAIL abort_no_result got 1 want 0"); end
    bus4.data_in = 32'h1111_2222; bus4.amount = 5'd3; bus4.mode = MODE_SRL;
    bus4.in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    abort = 1'b0;
    n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL abort_reject got busy=%b want 0", bus4.busy); end
    rose = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus4.out_valid) rose = 1'b1;
    end
    n_cmp++; if (rose) begin n_err++; $display("FAIL abort_reject_no_result got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    bit rose;
    send4(32'h0000_0001, 5'd31, MODE_SLL, 32'h8000_0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb4.delete();
    n_cmp++; if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ctrl got valid=%b busy=%b want 0/0", bus4.out_valid, bus4.busy);
    end
    n_cmp++; if (bus4.data_out !== 32'h0) begin n_err++; $display("FAIL rstmid_data got %h want 0", bus4.data_out); end
    n_cmp++; if (bus4.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", bus4.in_ready); end
    rose = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus4.out_valid) rose = 1'b1;
    end
    n_cmp++; if (rose) begin n_err++; $display("FAIL rstmid_no_result got 1 want 0"); end
  endtask

  task automatic test_step_variants();
    vec_t v;
    exp_t x1, x32;
    int lat1, lat32;
    bit seen1, seen32;
    for (int i = 0; i < 5; i++) begin
      v = spec_vec(i);
      x1.data = v.e;  x1.lat = exp_lat(int'(v.a), v.m, 1);
      x32.data = v.e; x32.lat = exp_lat(int'(v.a), v.m, 32);
      sb1.push_back(x1);
      sb32.push_back(x32);
      bus1.data_in = v.d;  bus1.amount = v.a;  bus1.mode = v.m;  bus1.in_valid = 1'b1;
      bus32.data_in = v.d; bus32.amount = v.a; bus32.mode = v.m; bus32.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus32.in_valid = 1'b0;
      seen1 = 1'b0; seen32 = 1'b0; lat1 = -1; lat32 = -1;
      for (int c = 1; c <= 64; c++) begin
        @(negedge clk);
        if (!seen1 && bus1.out_valid) begin seen1 = 1'b1; lat1 = c; end
        if (!seen32 && bus32.out_valid) begin seen32 = 1'b1; lat32 = c; end
        if (seen1 && seen32) break;
      end
      x1 = sb1.pop_front();
      x32 = sb32.pop_front();
      n_cmp++; if (!seen1 || bus1.data_out !== x1.data) begin n_err++; $display("FAIL step1_data[%0d] got %h want %h", i, bus1.data_out, x1.data); end
      n_cmp++; if (lat1 != x1.lat) begin n_err++; $display("FAIL step1_latency[%0d] got %0d want %0d", i, lat1, x1.lat); end
      n_cmp++; if (!seen32 || bus32.data_out !== x32.data) begin n_err++; $display("FAIL step32_data[%0d] got %h want %h", i, bus32.data_out, x32.data); end
      n_cmp++; if (lat32 != x32.lat) begin n_err++; $display("FAIL step32_latency[%0d] got %0d want %0d", i, lat32, x32.lat); end
      bus1.out_ready = 1'b1;
      bus32.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      bus32.out_ready = 1'b0;
    end
  endtask

  initial begin
    last_result = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_step_variants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
